// File: rtl/core_pipe_mem.sv
// core_pipe_mem: memory stage; owns the data bus, aligns/extends loads, traps on faults.
// Optional misaligned-access trap enabled by defining CORE_MEM_MISALIGN_TRAP_EN.
`default_nettype none

module core_pipe_mem #(
  parameter int XLEN       = 64,
  parameter int MEM_ADDR_W = 64
) (
  input  logic                  g_clk,
  input  logic                  g_rst,
  input  logic                  s3_valid,
  output logic                  s3_ready,
  input  logic                  s3_load,
  input  logic                  s3_store,
  input  logic [1:0]            s3_width,
  input  logic                  s3_signed,
  input  logic [MEM_ADDR_W-1:0] s3_addr,
  input  logic [XLEN-1:0]       s3_wdata,
  input  logic [4:0]            s3_rd,
  output logic                  dmem_req,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic                  dmem_wen,
  output logic [7:0]            dmem_strb,
  output logic [63:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_err,
  input  logic [63:0]           dmem_rdata,
  output logic                  s3_rd_wen,
  output logic [4:0]            s3_rd_addr,
  output logic [XLEN-1:0]       s3_rd_wdata,
  output logic                  trap_valid,
  output logic [3:0]            trap_cause,
  output logic [XLEN-1:0]       trap_tval,
  input  logic                  trap_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  state_t                 state_q, state_d;
  logic                   store_q, store_d;
  logic [1:0]             width_q, width_d;
  logic                   signed_q, signed_d;
  logic [2:0]             off_q, off_d;
  logic [MEM_ADDR_W-1:3]  addr_q, addr_d;
  logic [7:0]             strb_q, strb_d;
  logic [63:0]            wdata_q, wdata_d;
  logic [4:0]             rd_q, rd_d;
  logic [XLEN-1:0]        rd_wdata_q, rd_wdata_d;
  logic [3:0]             cause_q, cause_d;
  logic [XLEN-1:0]        tval_q, tval_d;

  logic [2:0]  align_mask;
  logic [2:0]  eff_off;
  logic        misaligned;
  logic [7:0]  strb_base;
  logic [63:0] wdata_rep;
  logic [63:0] rdata_shift;
  logic [XLEN-1:0] load_result;

  // Low address bits that must be zero for the requested width.
  always_comb begin
    align_mask = 3'b111;
    case (s3_width)
      W_BYTE:  align_mask = 3'b000;
      W_HALF:  align_mask = 3'b001;
      W_WORD:  align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  assign misaligned = |(s3_addr[2:0] & align_mask);
`else
  assign misaligned = 1'b0;
`endif

  // Force-aligned lane offset; identical to addr[2:0] whenever the access is aligned.
  assign eff_off = s3_addr[2:0] & ~align_mask;

  always_comb begin
    strb_base = 8'hFF;
    wdata_rep = 64'(s3_wdata);
    case (s3_width)
      W_BYTE: begin
        strb_base = 8'h01;
        wdata_rep = {8{s3_wdata[7:0]}};
      end
      W_HALF: begin
        strb_base = 8'h03;
        wdata_rep = {4{s3_wdata[15:0]}};
      end
      W_WORD: begin
        strb_base = 8'h0F;
        wdata_rep = {2{s3_wdata[31:0]}};
      end
      default: begin
        strb_base = 8'hFF;
        wdata_rep = 64'(s3_wdata);
      end
    endcase
  end

  assign rdata_shift = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_result = XLEN'(rdata_shift);
    case (width_q)
      W_BYTE: load_result = {{(XLEN-8){signed_q & rdata_shift[7]}}, rdata_shift[7:0]};
      W_HALF: load_result = {{(XLEN-16){signed_q & rdata_shift[15]}}, rdata_shift[15:0]};
      W_WORD: load_result = {{(XLEN-32){signed_q & rdata_shift[31]}}, rdata_shift[31:0]};
      default: load_result = XLEN'(rdata_shift);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    width_d    = width_q;
    signed_d   = signed_q;
    off_d      = off_q;
    addr_d     = addr_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rd_wdata_d = rd_wdata_q;
    cause_d    = cause_q;
    tval_d     = tval_q;

    case (state_q)
      ST_IDLE: begin
        if (s3_valid && (s3_load || s3_store)) begin
          store_d  = s3_store;
          width_d  = s3_width;
          signed_d = s3_signed;
          off_d    = eff_off;
          addr_d   = s3_addr[MEM_ADDR_W-1:3];
          strb_d   = strb_base << eff_off;
          wdata_d  = wdata_rep;
          rd_d     = s3_rd;
          tval_d   = XLEN'(s3_addr);
          if (misaligned) begin
            cause_d = s3_store ? 4'd6 : 4'd4;
            state_d = ST_TRAP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (dmem_err) begin
            cause_d = store_q ? 4'd7 : 4'd5;
            state_d = ST_TRAP;
          end else if (!store_q) begin
            rd_wdata_d = load_result;
            state_d    = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WB: state_d = ST_IDLE;
      ST_TRAP: begin
        if (trap_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q    <= ST_IDLE;
      store_q    <= 1'b0;
      width_q    <= 2'd0;
      signed_q   <= 1'b0;
      off_q      <= 3'd0;
      addr_q     <= '0;
      strb_q     <= 8'd0;
      wdata_q    <= 64'd0;
      rd_q       <= 5'd0;
      rd_wdata_q <= '0;
      cause_q    <= 4'd0;
      tval_q     <= '0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      width_q    <= width_d;
      signed_q   <= signed_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rd_wdata_q <= rd_wdata_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
    end
  end

  // Request is gated by reset too so it drops the instant reset rises.
  assign dmem_req    = (state_q == ST_REQ) && !g_rst;
  assign dmem_wen    = dmem_req && store_q;
  assign dmem_addr   = {addr_q, 3'b000};
  assign dmem_strb   = strb_q;
  assign dmem_wdata  = wdata_q;
  assign s3_ready    = (state_q == ST_IDLE);
  assign s3_rd_wen   = (state_q == ST_WB) && (rd_q != 5'd0);
  assign s3_rd_addr  = rd_q;
  assign s3_rd_wdata = rd_wdata_q;
  assign trap_valid  = (state_q == ST_TRAP);
  assign trap_cause  = cause_q;
  assign trap_tval   = tval_q;

endmodule

`default_nettype wire
